// File: rtl/calc_token_store.sv
// Token program store: loads a default expression after reset, accepts host
// writes while idle, and streams tokens to the parser until the end marker.
module calc_token_store #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 100,
   parameter int unsigned ADDR_W    = 7,
   parameter int unsigned END_TOKEN = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   output logic              tok_valid,
   input  logic              tok_ready,
   output logic [DATA_W-1:0] tok_data,
   output logic [ADDR_W-1:0] tok_addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned     INIT_W    = 3;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {INIT, IDLE, STREAM, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] ptr;
   logic [INIT_W-1:0] init_cnt;
   logic [DATA_W-1:0] init_word;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              in_range;
   logic              xfer;
   logic              is_end;

   // Built-in default program image for addresses 0..7
   always_comb begin
      init_word = DATA_W'(END_TOKEN);
      case (init_cnt)
         3'd0:    init_word = DATA_W'(1);
         3'd1:    init_word = DATA_W'(5);
         3'd2:    init_word = DATA_W'(21);
         3'd3:    init_word = DATA_W'(1);
         3'd4:    init_word = DATA_W'(0);
         3'd5:    init_word = DATA_W'(20);
         3'd6:    init_word = DATA_W'(9);
         default: init_word = DATA_W'(END_TOKEN);
      endcase
   end

   assign in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));

   // Write port arbitration: INIT image loader owns the port, host only in IDLE
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (state == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = ADDR_W'(init_cnt);
         mem_wdata = init_word;
      end else if (state == IDLE && wr_en && in_range) begin
         mem_we = 1'b1;
      end
   end

   // Storage is deliberately not reset so host data survives a reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign tok_data = mem[ptr];
   assign tok_addr = ptr;
   assign is_end   = (tok_data == DATA_W'(END_TOKEN));
   assign xfer     = tok_valid && tok_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         ptr       <= '0;
         init_cnt  <= '0;
         tok_valid <= 1'b0;
         busy      <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + INIT_W'(1);
               if (init_cnt == INIT_W'(7)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE: begin
               if (start) begin
                  state     <= STREAM;
                  ptr       <= '0;
                  err       <= 1'b0;
                  tok_valid <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (is_end) begin
                     state     <= DONE;
                     tok_valid <= 1'b0;
                     done      <= 1'b1;
                  end else if (ptr == LAST_ADDR) begin
                     // Ran off the end of the store without a terminator
                     state     <= IDLE;
                     ptr       <= '0;
                     err       <= 1'b1;
                     tok_valid <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     ptr <= ptr + ADDR_W'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= INIT;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule
